anffl_tex_bilinear: RTL

Bilinear texture filter stage directly downstream of the texture color decoder. It takes one filter request carrying the 4-bit sub-texel fractions. It then consumes the four decoded RGBA8888 texels of the 2x2 footprint, one per handshake. Each channel is weighted and accumulated, and one rounded RGBA8888 sample is presented to the shader/raster return path.

---
 rtl/anffl_tex_bilinear.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/anffl_tex_bilinear.sv
`default_nettype none
// ============================================================================
//  Module      : anffl_tex_bilinear
//  Description : Bilinear texture filter. Accepts one request carrying the
//                sub-texel fractions, accumulates four weighted RGBA8888
//                texels of the 2x2 footprint (T00, T10, T01, T11 in that
//                order), then presents one rounded RGBA8888 sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module anffl_tex_bilinear #(
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    // Filter request
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [FRAC_W-1:0] frac_u,
    input  logic [FRAC_W-1:0] frac_v,

    // Decoded texel stream
    input  logic              texel_valid,
    output logic              texel_ready,
    input  logic [7:0]        texel_r,
    input  logic [7:0]        texel_g,
    input  logic [7:0]        texel_b,
    input  logic [7:0]        texel_a,

    // Filtered sample
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_r,
    output logic [7:0]        out_g,
    output logic [7:0]        out_b,
    output logic [7:0]        out_a
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    // One-axis weight (2^FRAC_W - f) needs one extra bit to hold 2^FRAC_W.
    localparam int U_W    = FRAC_W + 1;
    // Combined weight reaches 2^(2*FRAC_W) exactly, so one extra bit again.
    localparam int WGT_W  = 2 * FRAC_W + 1;
    // 8-bit channel times total weight 2^(2*FRAC_W) never exceeds this width.
    localparam int ACC_W  = 2 * FRAC_W + 8;
    localparam int NUM_CH = 4;

    localparam logic [U_W-1:0]   c_ONE  = U_W'(1) << FRAC_W;
    // Half of the total weight, used for round-to-nearest on the output.
    localparam logic [ACC_W-1:0] c_HALF = ACC_W'(1) << (2 * FRAC_W - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ACCUM = 2'd1;
    localparam logic [1:0] c_OUT   = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [1:0]        r_idx;
    logic [FRAC_W-1:0] r_frac_u;
    logic [FRAC_W-1:0] r_frac_v;

    // Handshake qualifiers; readiness is decoded from the registered state only
    logic w_req_fire;
    logic w_tex_fire;
    logic w_out_fire;

    assign req_ready   = (r_state == c_IDLE);
    assign texel_ready = (r_state == c_ACCUM);
    assign out_valid   = (r_state == c_OUT);

    assign w_req_fire  = req_valid   && req_ready;
    assign w_tex_fire  = texel_valid && texel_ready;
    assign w_out_fire  = out_valid   && out_ready;

    // Next-state selection for the IDLE -> ACCUM -> OUT -> IDLE sequence
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_req_fire) begin
                    w_state_nxt = c_ACCUM;
                end
            end
            c_ACCUM: begin
                if (w_tex_fire && (r_idx == 2'd3)) begin
                    w_state_nxt = c_OUT;
                end
            end
            c_OUT: begin
                if (w_out_fire) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fractions are captured once per request and held for the whole footprint
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frac_u <= '0;
            r_frac_v <= '0;
        end else if (w_req_fire) begin
            r_frac_u <= frac_u;
            r_frac_v <= frac_v;
        end
    end

    // Texel index: cleared on request, advances only on a texel handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx <= 2'd0;
        end else if (w_req_fire) begin
            r_idx <= 2'd0;
        end else if (w_tex_fire) begin
            r_idx <= r_idx + 2'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Bilinear weights
    // ------------------------------------------------------------------------
    logic [U_W-1:0]   w_fu;
    logic [U_W-1:0]   w_fv;
    logic [U_W-1:0]   w_u;
    logic [U_W-1:0]   w_v;
    logic [WGT_W-1:0] w_fu_x;
    logic [WGT_W-1:0] w_fv_x;
    logic [WGT_W-1:0] w_u_x;
    logic [WGT_W-1:0] w_v_x;
    logic [WGT_W-1:0] w_wgt [NUM_CH];
    logic [WGT_W-1:0] w_sel_wgt;

    assign w_fu   = {1'b0, r_frac_u};
    assign w_fv   = {1'b0, r_frac_v};
    assign w_u    = c_ONE - w_fu;
    assign w_v    = c_ONE - w_fv;

    // Widen before multiplying so the product is formed at weight width
    assign w_fu_x = {{(WGT_W - U_W){1'b0}}, w_fu};
    assign w_fv_x = {{(WGT_W - U_W){1'b0}}, w_fv};
    assign w_u_x  = {{(WGT_W - U_W){1'b0}}, w_u};
    assign w_v_x  = {{(WGT_W - U_W){1'b0}}, w_v};

    // Weight table in texel arrival order: T00, T10, T01, T11
    assign w_wgt[0] = w_u_x  * w_v_x;
    assign w_wgt[1] = w_fu_x * w_v_x;
    assign w_wgt[2] = w_u_x  * w_fv_x;
    assign w_wgt[3] = w_fu_x * w_fv_x;

    assign w_sel_wgt = w_wgt[r_idx];

    // ------------------------------------------------------------------------
    // Per-channel multiply-accumulate and rounding
    // ------------------------------------------------------------------------
    logic [NUM_CH-1:0][7:0] w_texel;
    logic [NUM_CH-1:0][7:0] w_out;

    assign w_texel[0] = texel_r;
    assign w_texel[1] = texel_g;
    assign w_texel[2] = texel_b;
    assign w_texel[3] = texel_a;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            logic [ACC_W-1:0] r_acc;
            logic [ACC_W-1:0] w_prod;

            // 8-bit texel times weight; the full sum of four terms fits ACC_W
            assign w_prod = {{(ACC_W - 8){1'b0}}, w_texel[gi]}
                          * {{(ACC_W - WGT_W){1'b0}}, w_sel_wgt};

            // Accumulator: cleared per request, holds while in OUT
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_acc <= '0;
                end else if (w_req_fire) begin
                    r_acc <= '0;
                end else if (w_tex_fire) begin
                    r_acc <= r_acc + w_prod;
                end
            end

            // Round to nearest and drop the weight scale; never exceeds 255
            assign w_out[gi] = 8'((r_acc + c_HALF) >> (2 * FRAC_W));
        end
    endgenerate

    assign out_r = w_out[0];
    assign out_g = w_out[1];
    assign out_b = w_out[2];
    assign out_a = w_out[3];

endmodule
`default_nettype wire
